// File: rtl/rv_pkg.sv
// Shared core types: memory access size plus the memory arbiter's
// FSM state and grant encodings.
package rv_pkg;

    typedef enum logic [1:0] {
        MEM_BYTE = 2'd0,
        MEM_HALF = 2'd1,
        MEM_WORD = 2'd2
    } mem_size_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } arb_state_t;

    typedef enum logic {
        GRANT_R0 = 1'b0,
        GRANT_R1 = 1'b1
    } arb_grant_t;

    function automatic arb_grant_t other_grant(input arb_grant_t g);
        return (g == GRANT_R0) ? GRANT_R1 : GRANT_R0;
    endfunction

endpackage

// File: rtl/mem_arb_wdt.sv
// Transaction watchdog: counts cycles while i_run is high and flags
// the cycle in which LIMIT cycles have elapsed.
module mem_arb_wdt #(
    parameter int unsigned LIMIT = 1024
) (
    input  logic i_clk,
    input  logic i_rstn,
    input  logic i_run,
    output logic o_expired
);

    localparam logic [15:0] LAST = 16'(LIMIT - 1);

    logic [15:0] count;

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            count <= '0;
        end else if (!i_run) begin
            count <= '0;
        end else if (count != LAST) begin
            count <= count + 16'd1;
        end
    end

    assign o_expired = i_run && (count == LAST);

endmodule

// File: rtl/mem_port_arbiter.sv
// Fetch/data memory port arbiter with a per-transaction watchdog.
// Define MEM_ARB_RR_EN for round-robin; default is fixed data-port priority.
module mem_port_arbiter
    import rv_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic        i_clk,
    input  logic        i_rstn,
    input  logic        i_r0_re,
    input  logic [31:0] i_r0_addr,
    output logic [31:0] o_r0_data,
    output logic        o_r0_ready,
    input  logic        i_r1_re,
    input  logic        i_r1_we,
    input  logic [31:0] i_r1_addr,
    input  logic [31:0] i_r1_data,
    input  mem_size_t   i_r1_size,
    output logic [31:0] o_r1_data,
    output logic        o_r1_ready,
    output logic        o_m_re,
    output logic        o_m_we,
    output logic [31:0] o_m_addr,
    output logic [31:0] o_m_data,
    output mem_size_t   o_m_size,
    input  logic [31:0] i_m_data,
    input  logic        i_m_data_ready,
    input  logic        i_m_write_ready,
    output logic        o_busy,
    output logic        o_timeout_err
);

    arb_state_t state;
    arb_grant_t grant;
    arb_grant_t pick;
    logic       r0_req;
    logic       r1_req;
    logic       mem_ack;
    logic       expired;

    assign r0_req  = i_r0_re;
    assign r1_req  = i_r1_re | i_r1_we;
    assign mem_ack = o_m_we ? i_m_write_ready : i_m_data_ready;
    assign o_busy  = (state != IDLE);

`ifdef MEM_ARB_RR_EN
    arb_grant_t prio;

    always_comb begin
        pick = GRANT_R1;
        if (r0_req && r1_req) begin
            pick = prio;
        end else if (r0_req) begin
            pick = GRANT_R0;
        end
    end
`else
    assign pick = r1_req ? GRANT_R1 : GRANT_R0;
`endif

    mem_arb_wdt #(
        .LIMIT(TIMEOUT_CYCLES)
    ) u_wdt (
        .i_clk    (i_clk),
        .i_rstn   (i_rstn),
        .i_run    (state == BUSY),
        .o_expired(expired)
    );

    always_ff @(posedge i_clk or negedge i_rstn) begin
        if (!i_rstn) begin
            state         <= IDLE;
            grant         <= GRANT_R1;
            o_m_re        <= 1'b0;
            o_m_we        <= 1'b0;
            o_m_addr      <= '0;
            o_m_data      <= '0;
            o_m_size      <= MEM_BYTE;
            o_r0_data     <= '0;
            o_r1_data     <= '0;
            o_r0_ready    <= 1'b0;
            o_r1_ready    <= 1'b0;
            o_timeout_err <= 1'b0;
`ifdef MEM_ARB_RR_EN
            prio          <= GRANT_R1;
`endif
        end else begin
            o_r0_ready <= 1'b0;
            o_r1_ready <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (r0_req || r1_req) begin
                        state <= BUSY;
                        grant <= pick;
`ifdef MEM_ARB_RR_EN
                        prio  <= other_grant(pick);
`endif
                        // A combined r1 re+we is issued as a write only
                        if (pick == GRANT_R1) begin
                            o_m_we   <= i_r1_we;
                            o_m_re   <= ~i_r1_we;
                            o_m_addr <= i_r1_addr;
                            o_m_data <= i_r1_data;
                            o_m_size <= i_r1_size;
                        end else begin
                            o_m_we   <= 1'b0;
                            o_m_re   <= 1'b1;
                            o_m_addr <= i_r0_addr;
                            o_m_data <= '0;
                            o_m_size <= MEM_WORD;
                        end
                    end
                end
                BUSY: begin
                    if (mem_ack || expired) begin
                        state  <= DONE;
                        o_m_re <= 1'b0;
                        o_m_we <= 1'b0;
                        if (grant == GRANT_R1) begin
                            o_r1_ready <= 1'b1;
                        end else begin
                            o_r0_ready <= 1'b1;
                        end
                    end
                    // Completion wins over a same-cycle timeout
                    if (mem_ack) begin
                        if (o_m_re && grant == GRANT_R1) begin
                            o_r1_data <= i_m_data;
                        end
                        if (o_m_re && grant == GRANT_R0) begin
                            o_r0_data <= i_m_data;
                        end
                    end else if (expired) begin
                        o_timeout_err <= 1'b1;
                        if (grant == GRANT_R1) begin
                            o_r1_data <= '0;
                        end else begin
                            o_r0_data <= '0;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model.
// Follows MEM_ARB_RR_EN the same way the design build does.
module tb_mem_port_arbiter;
    import rv_pkg::*;

    localparam int TMO   = 8;
    localparam int NEVER = 1000;

    logic        clk = 1'b0;
    logic        rstn;
    logic        r0_re;
    logic [31:0] r0_addr;
    logic [31:0] r0_rdata;
    logic        r0_ready;
    logic        r1_re;
    logic        r1_we;
    logic [31:0] r1_addr;
    logic [31:0] r1_wdata;
    mem_size_t   r1_size;
    logic [31:0] r1_rdata;
    logic        r1_ready;
    logic        m_re;
    logic        m_we;
    logic [31:0] m_addr;
    logic [31:0] m_wdata;
    mem_size_t   m_size;
    logic [31:0] m_rdata;
    logic        m_data_ready;
    logic        m_write_ready;
    logic        busy;
    logic        timeout_err;

    mem_port_arbiter #(
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .i_clk          (clk),
        .i_rstn         (rstn),
        .i_r0_re        (r0_re),
        .i_r0_addr      (r0_addr),
        .o_r0_data      (r0_rdata),
        .o_r0_ready     (r0_ready),
        .i_r1_re        (r1_re),
        .i_r1_we        (r1_we),
        .i_r1_addr      (r1_addr),
        .i_r1_data      (r1_wdata),
        .i_r1_size      (r1_size),
        .o_r1_data      (r1_rdata),
        .o_r1_ready     (r1_ready),
        .o_m_re         (m_re),
        .o_m_we         (m_we),
        .o_m_addr       (m_addr),
        .o_m_data       (m_wdata),
        .o_m_size       (m_size),
        .i_m_data       (m_rdata),
        .i_m_data_ready (m_data_ready),
        .i_m_write_ready(m_write_ready),
        .o_busy         (busy),
        .o_timeout_err  (timeout_err)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          failures = 0;
    int          lat0, lat1, first, served, last_grant;
    int          act_cnt, last_act, who_m;
    bit          pend0, pend1, cur_active, model_err;
    logic [31:0] exp_d0, exp_d1;
    logic [31:0] mem [logic [31:0]];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0] ^ 16'hBEEF, a[31:16] ^ 16'h1234};
    endfunction

    function automatic int pick_lat();
        int r;
        r = int'($urandom_range(0, 19));
        if (r < 16) return r % 5;
        case (r)
            16:      return 6;
            17:      return 7;
            18:      return 8;
            default: return NEVER;
        endcase
    endfunction

    task automatic complete(input int w);
        int          l;
        bit          tmo_hit;
        bit          wr;
        logic [31:0] a;
        if (w == 1 ? !pend1 : !pend0) begin
            chk(w == 1 ? "r1_rdy_extra" : "r0_rdy_extra", 32'd1, 32'd0);
            return;
        end
        chk("grant_order", 32'(w), 32'(served == 0 ? first : 1 - first));
        l       = (w == 1) ? lat1 : lat0;
        tmo_hit = (l >= TMO);
        chk("busy_cycles", 32'(last_act), 32'(tmo_hit ? TMO : l + 1));
        chk("busy_in_done", 32'(busy), 32'd1);
        wr = (w == 1) && r1_we;
        a  = (w == 1) ? r1_addr : r0_addr;
        if (tmo_hit) begin
            model_err = 1'b1;
            if (w == 1) exp_d1 = '0;
            else        exp_d0 = '0;
        end else if (!wr) begin
            if (w == 1) exp_d1 = mem_rd(a);
            else        exp_d0 = mem_rd(a);
        end
        if (w == 1) chk("r1_data", r1_rdata, exp_d1);
        else        chk("r0_data", r0_rdata, exp_d0);
        chk("timeout_err", 32'(timeout_err), 32'(model_err));
        last_grant = w;
        served++;
        if (w == 1) begin
            pend1 = 1'b0;
            r1_re = 1'b0;
            r1_we = 1'b0;
        end else begin
            pend0 = 1'b0;
            r0_re = 1'b0;
        end
    endtask

    // One cycle of memory responder plus output checks, run #1 after an edge
    task automatic step();
        bit act;
        bit junk;
        int l;
        act = m_re | m_we;
        if (act) begin
            if (!cur_active) begin
                cur_active = 1'b1;
                act_cnt    = 0;
                who_m      = (served == 0) ? first : 1 - first;
            end
            act_cnt++;
            if (who_m == 0) begin
                chk("m_op", 32'({m_we, m_re}), 32'd1);
                chk("m_addr", m_addr, r0_addr);
                chk("m_size", 32'(m_size), 32'(MEM_WORD));
            end else begin
                chk("m_op", 32'({m_we, m_re}), r1_we ? 32'd2 : 32'd1);
                chk("m_addr", m_addr, r1_addr);
                chk("m_size", 32'(m_size), 32'(r1_size));
                if (r1_we) chk("m_data", m_wdata, r1_wdata);
            end
            l = (who_m == 1) ? lat1 : lat0;
            if (act_cnt == l + 1) begin
                if (m_we) begin
                    m_write_ready = 1'b1;
                    m_data_ready  = 1'b0;
                    mem[m_addr]   = m_wdata;
                end else begin
                    m_data_ready  = 1'b1;
                    m_write_ready = 1'b0;
                    m_rdata       = mem_rd(m_addr);
                end
            end else begin
                m_data_ready  = 1'b0;
                m_write_ready = 1'b0;
            end
        end else begin
            if (cur_active) begin
                cur_active = 1'b0;
                last_act   = act_cnt;
            end
            junk          = ($urandom_range(0, 3) == 0);
            m_data_ready  = junk;
            m_write_ready = junk;
            m_rdata       = $urandom;
        end
        if (r0_ready && r1_ready) chk("both_ready", 32'd1, 32'd0);
        if (r0_ready) complete(0);
        if (r1_ready) complete(1);
    endtask

    task automatic run_round(input bit en0, input logic [31:0] a0,
                             input int l0, input bit re1, input bit we1,
                             input logic [31:0] a1, input logic [31:0] d1,
                             input mem_size_t s1, input int l1);
        bit en1;
        en1      = re1 | we1;
        r0_re    = en0;
        r0_addr  = a0;
        r1_re    = re1;
        r1_we    = we1;
        r1_addr  = a1;
        r1_wdata = d1;
        r1_size  = s1;
        lat0     = l0;
        lat1     = l1;
        pend0    = en0;
        pend1    = en1;
        served   = 0;
        if (en0 && en1) begin
`ifdef MEM_ARB_RR_EN
            first = (last_grant == 1) ? 0 : 1;
`else
            first = 1;
`endif
        end else begin
            first = en1 ? 1 : 0;
        end
        for (int c = 0; c < 80 && (pend0 || pend1); c++) begin
            @(posedge clk);
            #1;
            step();
        end
        if (pend0 || pend1) begin
            chk("round_budget", 32'd1, 32'd0);
            do_reset();
        end else begin
            @(posedge clk);
            #1;
            step();
            chk("r0_hold", r0_rdata, exp_d0);
            chk("r1_hold", r1_rdata, exp_d1);
        end
    endtask

    task automatic do_reset();
        rstn          = 1'b0;
        r0_re         = 1'b0;
        r1_re         = 1'b0;
        r1_we         = 1'b0;
        m_data_ready  = 1'b0;
        m_write_ready = 1'b0;
        pend0         = 1'b0;
        pend1         = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_mop", 32'({m_we, m_re}), 32'd0);
        chk("rst_ready", 32'({r1_ready, r0_ready}), 32'd0);
        chk("rst_err", 32'(timeout_err), 32'd0);
        chk("rst_r0_data", r0_rdata, 32'd0);
        chk("rst_r1_data", r1_rdata, 32'd0);
        chk("rst_m_addr", m_addr, 32'd0);
        chk("rst_m_data", m_wdata, 32'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            chk("rst_no_ready", 32'({r1_ready, r0_ready}), 32'd0);
        end
        rstn       = 1'b1;
        model_err  = 1'b0;
        last_grant = 0;
        exp_d0     = '0;
        exp_d1     = '0;
        cur_active = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_timeout got=running exp=finished");
        $fatal(1);
    end

    initial begin
        r0_addr  = '0;
        r1_addr  = '0;
        r1_wdata = '0;
        r1_size  = MEM_BYTE;
        m_rdata  = '0;
        act_cnt  = 0;
        last_act = 0;
        who_m    = 0;
        @(posedge clk);
        #1;
        do_reset();

        run_round(1'b0, 32'h0, 0, 1'b0, 1'b1, 32'h100, 32'hCAFEBABE,
                  MEM_WORD, 3);
        chk("wr_mem", mem_rd(32'h100), 32'hCAFEBABE);

        for (int i = 0; i < 5; i++) begin
            run_round(1'b1, 32'h40, 1, 1'b1, 1'b0, 32'h0010_0040,
                      32'h0, MEM_WORD, 2);
        end

        run_round(1'b0, 32'h0, 0, 1'b1, 1'b1, 32'h0010_0200,
                  32'h1234_5678, MEM_HALF, 1);
        run_round(1'b1, 32'h44, 7, 1'b0, 1'b0, 32'h0, 32'h0, MEM_WORD, 0);
        run_round(1'b1, 32'h48, NEVER, 1'b0, 1'b0, 32'h0, 32'h0,
                  MEM_WORD, 0);
        run_round(1'b0, 32'h0, 0, 1'b0, 1'b1, 32'h0010_0300,
                  32'hA5A5_5A5A, MEM_BYTE, 2);

        m_data_ready  = 1'b0;
        m_write_ready = 1'b0;
        r0_re         = 1'b1;
        r0_addr       = 32'h80;
        @(posedge clk);
        #1;
        chk("abort_busy1", 32'({m_we, m_re}), 32'd1);
        @(posedge clk);
        #1;
        chk("abort_busy2", 32'(busy), 32'd1);
        do_reset();
        run_round(1'b1, 32'h80, 2, 1'b0, 1'b0, 32'h0, 32'h0, MEM_WORD, 0);

        for (int i = 0; i < 300; i++) begin
            bit          e0;
            bit          re;
            bit          we;
            int          mode;
            logic [31:0] a0;
            logic [31:0] a1;
            e0   = 1'($urandom_range(0, 1));
            mode = int'($urandom_range(0, 3));
            re   = (mode == 1) || (mode == 3);
            we   = (mode == 2) || (mode == 3);
            if (!e0 && !re && !we) re = 1'b1;
            a0 = $urandom & 32'h0000_FFFC;
            a1 = 32'h0010_0000 + ($urandom & 32'h000F_FFFC);
            run_round(e0, a0, pick_lat(), re, we, a1, $urandom,
                      mem_size_t'($urandom_range(0, 2)), pick_lat());
            if (i % 60 == 59) do_reset();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
